// File: rtl/sms_card_por_seq.sv
// sms_card_por_seq
// Power-on / console reset sequencer card. Takes the upstream -RESET line,
// synchronises its release to clk, waits a settle period and then frees
// NSTAGES reset domains one after another with a fixed gap between them.
// A debounced console push-button re-runs the same sequence at any time.
module sms_card_por_seq #(
    parameter int NSTAGES     = 3,  // staged reset domains, 1..8
    parameter int HOLD_CYCLES = 4,  // settle edges before stage 0 frees, >=1
    parameter int STAGE_GAP   = 2,  // edges between consecutive stage releases, >=1
    parameter int DEBOUNCE    = 8   // equal synced samples needed to move the button level, >=1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               console_reset,
    output logic [NSTAGES-1:0] stage_rst_n,
    output logic [NSTAGES-1:0] stage_rst,
    output logic               ready
);

    // Counter widths: each counter only has to reach (terminal - 1) before it clears.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
    localparam int DB_W   = (DEBOUNCE > 1)    ? $clog2(DEBOUNCE)    : 1;
    localparam int IDX_W  = (NSTAGES > 1)     ? $clog2(NSTAGES)     : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NSTAGES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,   // waiting for the synchronised reset release
        ST_HOLD  = 2'd1,   // counting the settle period
        ST_STAGE = 2'd2,   // freeing stages 1..NSTAGES-1
        ST_RUN   = 2'd3    // everything released
    } state_t;

    // Reset-release synchroniser
    logic rst_s1_q, rst_s1_d;
    logic rst_s2_q, rst_s2_d;

    // Console button synchroniser and debouncer
    logic            btn_s1_q, btn_s1_d;
    logic            btn_s2_q, btn_s2_d;
    logic            btn_db_q, btn_db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_rise;

    // Sequencer
    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hold_tick;

    // Release events handed from the next-state logic to the output logic
    logic               rel_en;
    logic [IDX_W-1:0]   rel_idx;
    logic               rel_last;
    logic               seq_clear;
    logic [NSTAGES-1:0] rel_hit;

    // Registered outputs
    logic [NSTAGES-1:0] stage_rst_n_q, stage_rst_n_d;
    logic               ready_q, ready_d;

    // Synchroniser inputs: reset chain shifts in a constant 1 once reset_n is high.
    always_comb begin
        rst_s1_d = 1'b1;
        rst_s2_d = rst_s1_q;
        btn_s1_d = console_reset;
        btn_s2_d = btn_s1_q;
    end

    // Debounce: the level flips only after DEBOUNCE consecutive differing samples.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = ~btn_db_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    assign btn_rise = btn_db_d & ~btn_db_q;

    // A settle edge counts once the release is synchronised and the button is not held.
    assign hold_tick = ((state_q == ST_SYNC) && rst_s2_q) ||
                       ((state_q == ST_HOLD) && !btn_db_q);

    // State register, counters, synchronisers and output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_s1_q      <= 1'b0;
            rst_s2_q      <= 1'b0;
            btn_s1_q      <= 1'b0;
            btn_s2_q      <= 1'b0;
            btn_db_q      <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= ST_SYNC;
            hold_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= '0;
            stage_rst_n_q <= '0;
            ready_q       <= 1'b0;
        end else begin
            rst_s1_q      <= rst_s1_d;
            rst_s2_q      <= rst_s2_d;
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            btn_db_q      <= btn_db_d;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            idx_q         <= idx_d;
            stage_rst_n_q <= stage_rst_n_d;
            ready_q       <= ready_d;
        end
    end

    // Next-state logic: a new button press pre-empts whatever the sequencer was doing.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idx_d      = idx_q;
        rel_en     = 1'b0;
        rel_idx    = idx_q;
        rel_last   = 1'b0;
        seq_clear  = 1'b0;

        if (btn_rise) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            idx_d      = '0;
            seq_clear  = 1'b1;
        end else begin
            case (state_q)
                ST_SYNC, ST_HOLD: begin
                    if (hold_tick) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            // Last settle edge frees stage 0.
                            hold_cnt_d = '0;
                            rel_en     = 1'b1;
                            rel_idx    = '0;
                            if (NSTAGES == 1) begin
                                rel_last = 1'b1;
                                state_d  = ST_RUN;
                            end else begin
                                state_d   = ST_STAGE;
                                idx_d     = IDX_ONE;
                                gap_cnt_d = '0;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_ONE;
                            state_d    = ST_HOLD;
                        end
                    end else begin
                        // Button still held (or release not yet synchronised): no progress.
                        hold_cnt_d = '0;
                    end
                end
                ST_STAGE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        rel_en    = 1'b1;
                        rel_idx   = idx_q;
                        if (idx_q == IDX_LAST) begin
                            rel_last = 1'b1;
                            idx_d    = '0;
                            state_d  = ST_RUN;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_ONE;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    // Decode the single stage being released this edge into a one-hot mask.
    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_rel
            assign rel_hit[gi] = rel_en && (rel_idx == IDX_W'(gi));
        end
    endgenerate

    // Output logic: released stages stay released until a restart clears them all.
    always_comb begin
        stage_rst_n_d = stage_rst_n_q | rel_hit;
        ready_d       = ready_q | rel_last;
        if (seq_clear) begin
            stage_rst_n_d = '0;
            ready_d       = 1'b0;
        end
    end

    assign stage_rst_n = stage_rst_n_q;
    assign stage_rst   = ~stage_rst_n_q;
    assign ready       = ready_q;

endmodule
